fifo_rd_stream: RTL

- Read-side drain controller for the 16x8 synchronous FIFO.
- Pops bytes through the FIFO's rd_en/data_out/empty interface and presents them downstream as a valid/ready stream.
- Hides the FIFO's one-cycle read latency with a 2-entry skid buffer, so it sustains one byte per clock under continuous m_ready.
- Sits between the FIFO and any byte consumer; the FIFO's writer side is unaffected.

---
 rtl/fifo_rd_stream_if.sv | 22 ++
 rtl/fifo_rd_stream.sv | 92 +++++++++
 2 files changed

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read port and downstream byte stream bundle for fifo_rd_stream.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    // master: the drain controller; slave: the FIFO plus the downstream consumer.
    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO drain controller with 2-entry skid buffer presenting a valid/ready byte stream.
module fifo_rd_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    output logic [CNT_W-1:0]   rd_count,
    output logic               busy,
    fifo_rd_stream_if.master   bus
);
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic             head_q, tail_q;
    logic [WIDTH-1:0] buf_q [2];
    logic [CNT_W-1:0] cnt_q;

    logic             pop_out;
    logic             pop_fifo;
    logic             capture;
    logic [2:0]       level;

    assign pop_out = (occ_q != 2'd0) & bus.m_ready;

    // Entries held plus the byte still on its way, after this cycle's beat leaves.
    assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_out};

    assign bus.fifo_rd_en = rst & ~bus.fifo_empty & (state_q != S_FLUSH) & ~flush
                          & (level < 3'd2);
    assign pop_fifo = bus.fifo_rd_en & ~bus.fifo_empty;

    // A landing byte is dropped whenever a flush is active or in progress.
    assign capture = inflight_q & (state_q != S_FLUSH) & ~flush;

    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q + {1'b0, capture} - {1'b0, pop_out};
        inflight_d = pop_fifo;
        case (state_q)
            S_IDLE: begin
                if (bus.fifo_rd_en) state_d = S_STREAM;
            end
            S_STREAM: begin
                if ((occ_q == 2'd0) && !inflight_q && !pop_fifo) state_d = S_IDLE;
            end
            S_FLUSH: begin
                if (!flush && !inflight_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_FLUSH;
            occ_d   = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            cnt_q      <= '0;
            for (int i = 0; i < 2; i++) buf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            if (pop_out) cnt_q <= cnt_q + 1'b1;
            if (flush) begin
                head_q <= 1'b0;
                tail_q <= 1'b0;
            end else begin
                if (capture) begin
                    buf_q[tail_q] <= bus.fifo_data;
                    tail_q        <= ~tail_q;
                end
                if (pop_out) head_q <= ~head_q;
            end
        end
    end

    assign bus.m_valid = (occ_q != 2'd0);
    assign bus.m_data  = buf_q[head_q];
    assign rd_count    = cnt_q;
    assign busy        = (occ_q != 2'd0) | inflight_q | (state_q == S_FLUSH);
endmodule
